// File: rtl/bank_register_mp.sv
// ---------------------------------------------------------------------------
// bank_register_mp
//   Multi-ported register bank with a load scoreboard and a sequential clear.
//   Two combinational read ports see same-cycle writes through a bypass
//   (port A has priority over port B). Each entry carries a pending bit that
//   is set by a load claim and cleared by the load writeback on port B. A
//   clear request walks the bank one entry per cycle, zeroing data and
//   pending bits.
//
// Ports
//   clock, reset_n           rising-edge clock, asynchronous active-low reset
//   rd_addr1/2, rd_data1/2   read addresses and bypassed read data
//   busy1/2                  registered pending bit of rd_addr1 / rd_addr2
//   wr_en_a/wr_addr_a/wr_data_a   write port A (ALU writeback)
//   wr_en_b/wr_addr_b/wr_data_b   write port B (load writeback, clears pending)
//   claim_en/claim_addr      mark an entry pending (load issued)
//   clear_req                start a full sequential clear
//   clear_busy               high while the clear sequence runs
// ---------------------------------------------------------------------------
`timescale 1ns/1ps
module bank_register_mp #(
    parameter int DATA_W   = 32,
    parameter int ADDR_W   = 5,
    parameter int ZERO_REG = 1
) (
    input  logic              clock,
    input  logic              reset_n,
    input  logic [ADDR_W-1:0] rd_addr1,
    input  logic [ADDR_W-1:0] rd_addr2,
    output logic [DATA_W-1:0] rd_data1,
    output logic [DATA_W-1:0] rd_data2,
    output logic              busy1,
    output logic              busy2,
    input  logic              wr_en_a,
    input  logic [ADDR_W-1:0] wr_addr_a,
    input  logic [DATA_W-1:0] wr_data_a,
    input  logic              wr_en_b,
    input  logic [ADDR_W-1:0] wr_addr_b,
    input  logic [DATA_W-1:0] wr_data_b,
    input  logic              claim_en,
    input  logic [ADDR_W-1:0] claim_addr,
    input  logic              clear_req,
    output logic              clear_busy
);

    localparam int DEPTH = 32'sd1 << ADDR_W;
    localparam bit ZERO_EN = (ZERO_REG != 32'sd0);
    localparam logic [ADDR_W-1:0] ADDR_ZERO = {ADDR_W{1'b0}};
    localparam logic [ADDR_W-1:0] ADDR_LAST = {ADDR_W{1'b1}};
    localparam logic [ADDR_W-1:0] ADDR_ONE  = {{(ADDR_W-1){1'b0}}, 1'b1};

    typedef enum logic [0:0] {
        ST_IDLE  = 1'b0,
        ST_CLEAR = 1'b1
    } state_t;

    state_t              state_r;
    logic [ADDR_W-1:0]   idx_r;
    logic                clear_busy_r;
    logic [DATA_W-1:0]   regs_r [DEPTH];
    logic [DEPTH-1:0]    pend_r;

    logic                idle_s;
    logic                clr_en_s;
    logic                we_a_s;
    logic                we_b_s;
    logic                claim_s;

    // Qualify write/claim requests: only in IDLE, never to the hard-wired zero entry.
    always_comb begin
        idle_s   = (state_r == ST_IDLE);
        clr_en_s = (state_r == ST_CLEAR);
        we_a_s   = wr_en_a  & idle_s & ~(ZERO_EN & (wr_addr_a  == ADDR_ZERO));
        we_b_s   = wr_en_b  & idle_s & ~(ZERO_EN & (wr_addr_b  == ADDR_ZERO));
        claim_s  = claim_en & idle_s & ~(ZERO_EN & (claim_addr == ADDR_ZERO));
    end

    // Read port 1: zero entry, then bypass A, then bypass B, else stored data.
    always_comb begin
        rd_data1 = regs_r[rd_addr1];
        if (ZERO_EN && (rd_addr1 == ADDR_ZERO)) begin
            rd_data1 = {DATA_W{1'b0}};
        end else if (we_a_s && (wr_addr_a == rd_addr1)) begin
            rd_data1 = wr_data_a;
        end else if (we_b_s && (wr_addr_b == rd_addr1)) begin
            rd_data1 = wr_data_b;
        end else begin
            rd_data1 = regs_r[rd_addr1];
        end
    end

    // Read port 2: same priority as read port 1.
    always_comb begin
        rd_data2 = regs_r[rd_addr2];
        if (ZERO_EN && (rd_addr2 == ADDR_ZERO)) begin
            rd_data2 = {DATA_W{1'b0}};
        end else if (we_a_s && (wr_addr_a == rd_addr2)) begin
            rd_data2 = wr_data_a;
        end else if (we_b_s && (wr_addr_b == rd_addr2)) begin
            rd_data2 = wr_data_b;
        end else begin
            rd_data2 = regs_r[rd_addr2];
        end
    end

    // Scoreboard outputs come straight from the registered pending bits.
    assign busy1      = pend_r[rd_addr1];
    assign busy2      = pend_r[rd_addr2];
    assign clear_busy = clear_busy_r;

    // Clear sequencer: walks idx_r from 0 to all-ones once, then returns to IDLE.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_r      <= ST_IDLE;
            idx_r        <= ADDR_ZERO;
            clear_busy_r <= 1'b0;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (clear_req) begin
                        state_r      <= ST_CLEAR;
                        idx_r        <= ADDR_ZERO;
                        clear_busy_r <= 1'b1;
                    end else begin
                        state_r      <= ST_IDLE;
                        idx_r        <= idx_r;
                        clear_busy_r <= 1'b0;
                    end
                end
                ST_CLEAR: begin
                    if (idx_r == ADDR_LAST) begin
                        state_r      <= ST_IDLE;
                        idx_r        <= ADDR_ZERO;
                        clear_busy_r <= 1'b0;
                    end else begin
                        state_r      <= ST_CLEAR;
                        idx_r        <= idx_r + ADDR_ONE;
                        clear_busy_r <= 1'b1;
                    end
                end
                default: begin
                    state_r      <= ST_IDLE;
                    idx_r        <= ADDR_ZERO;
                    clear_busy_r <= 1'b0;
                end
            endcase
        end
    end

    // Storage and pending bits; port A beats port B on data, a claim beats a port-B clear.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                regs_r[i] <= {DATA_W{1'b0}};
            end
            pend_r <= {DEPTH{1'b0}};
        end else begin
            for (int i = 0; i < DEPTH; i++) begin
                if (clr_en_s && (idx_r == ADDR_W'(i))) begin
                    regs_r[i] <= {DATA_W{1'b0}};
                end else if (we_a_s && (wr_addr_a == ADDR_W'(i))) begin
                    regs_r[i] <= wr_data_a;
                end else if (we_b_s && (wr_addr_b == ADDR_W'(i))) begin
                    regs_r[i] <= wr_data_b;
                end else begin
                    regs_r[i] <= regs_r[i];
                end

                if (clr_en_s && (idx_r == ADDR_W'(i))) begin
                    pend_r[i] <= 1'b0;
                end else if (claim_s && (claim_addr == ADDR_W'(i))) begin
                    pend_r[i] <= 1'b1;
                end else if (we_b_s && (wr_addr_b == ADDR_W'(i))) begin
                    pend_r[i] <= 1'b0;
                end else begin
                    pend_r[i] <= pend_r[i];
                end
            end
        end
    end

endmodule

// File: tb/tb_bank_register_mp.sv
// ---------------------------------------------------------------------------
// tb_bank_register_mp
//   Directed self-checking bench for bank_register_mp (DATA_W=32, ADDR_W=5,
//   ZERO_REG=1). Inputs change 1 ns after a rising edge; outputs are sampled
//   a further 1 ns later, well away from the next edge.
// ---------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_bank_register_mp;

    logic        clock;
    logic        reset_n;
    logic [4:0]  rd_addr1, rd_addr2;
    logic [31:0] rd_data1, rd_data2;
    logic        busy1, busy2;
    logic        wr_en_a;
    logic [4:0]  wr_addr_a;
    logic [31:0] wr_data_a;
    logic        wr_en_b;
    logic [4:0]  wr_addr_b;
    logic [31:0] wr_data_b;
    logic        claim_en;
    logic [4:0]  claim_addr;
    logic        clear_req;
    logic        clear_busy;

    int n_checks;
    int n_errors;

    bank_register_mp #(
        .DATA_W   (32),
        .ADDR_W   (5),
        .ZERO_REG (1)
    ) dut (
        .clock      (clock),
        .reset_n    (reset_n),
        .rd_addr1   (rd_addr1),
        .rd_addr2   (rd_addr2),
        .rd_data1   (rd_data1),
        .rd_data2   (rd_data2),
        .busy1      (busy1),
        .busy2      (busy2),
        .wr_en_a    (wr_en_a),
        .wr_addr_a  (wr_addr_a),
        .wr_data_a  (wr_data_a),
        .wr_en_b    (wr_en_b),
        .wr_addr_b  (wr_addr_b),
        .wr_data_b  (wr_data_b),
        .claim_en   (claim_en),
        .claim_addr (claim_addr),
        .clear_req  (clear_req),
        .clear_busy (clear_busy)
    );

    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    // Advance one rising edge, then move 1 ns past it.
    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic idle_inputs();
        wr_en_a   = 1'b0; wr_addr_a = 5'd0; wr_data_a = 32'd0;
        wr_en_b   = 1'b0; wr_addr_b = 5'd0; wr_data_b = 32'd0;
        claim_en  = 1'b0; claim_addr = 5'd0;
        clear_req = 1'b0;
    endtask

    initial begin
        int cnt;
        n_checks = 0;
        n_errors = 0;
        reset_n  = 1'b0;
        rd_addr1 = 5'd5;
        rd_addr2 = 5'd9;
        idle_inputs();

        // Reset state
        #2;
        check_eq("rst_rd1", rd_data1, 32'h0);
        check_eq("rst_busy2", {31'd0, busy2}, 32'd0);
        check_eq("rst_clear_busy", {31'd0, clear_busy}, 32'd0);
        repeat (2) step();
        @(negedge clock);
        reset_n = 1'b1;
        step();

        // Write A addr 3 with same-cycle bypass, then stored value
        wr_en_a = 1'b1; wr_addr_a = 5'd3; wr_data_a = 32'h0000_1234;
        rd_addr1 = 5'd3;
        #1;
        check_eq("bypass_a3", rd_data1, 32'h0000_1234);
        step();
        wr_en_a = 1'b0;
        #1;
        check_eq("stored_a3", rd_data1, 32'h0000_1234);

        // A and B to addr 7: A wins both in bypass and storage
        wr_en_a = 1'b1; wr_addr_a = 5'd7; wr_data_a = 32'hAAAA_AAAA;
        wr_en_b = 1'b1; wr_addr_b = 5'd7; wr_data_b = 32'h5555_5555;
        rd_addr2 = 5'd7;
        #1;
        check_eq("bypass_ab7", rd_data2, 32'hAAAA_AAAA);
        step();
        idle_inputs();
        #1;
        check_eq("stored_ab7", rd_data2, 32'hAAAA_AAAA);

        // Port B alone writes and bypasses
        wr_en_b = 1'b1; wr_addr_b = 5'd12; wr_data_b = 32'hCAFE_0012;
        rd_addr1 = 5'd12;
        #1;
        check_eq("bypass_b12", rd_data1, 32'hCAFE_0012);
        step();
        idle_inputs();
        #1;
        check_eq("stored_b12", rd_data1, 32'hCAFE_0012);

        // Zero register: writes and claims to addr 0 are ignored
        wr_en_a = 1'b1; wr_addr_a = 5'd0; wr_data_a = 32'hFFFF_FFFF;
        wr_en_b = 1'b1; wr_addr_b = 5'd0; wr_data_b = 32'hFFFF_FFFF;
        claim_en = 1'b1; claim_addr = 5'd0;
        rd_addr1 = 5'd0;
        #1;
        check_eq("zero_bypass", rd_data1, 32'h0);
        step();
        idle_inputs();
        #1;
        check_eq("zero_stored", rd_data1, 32'h0);
        check_eq("zero_busy", {31'd0, busy1}, 32'd0);

        // Scoreboard on addr 9
        rd_addr1 = 5'd9;
        claim_en = 1'b1; claim_addr = 5'd9;
        #1;
        check_eq("claim_no_bypass", {31'd0, busy1}, 32'd0);
        step();
        idle_inputs();
        #1;
        check_eq("claim9_set", {31'd0, busy1}, 32'd1);
        claim_en = 1'b1; claim_addr = 5'd9;
        wr_en_b = 1'b1; wr_addr_b = 5'd9; wr_data_b = 32'h0000_0099;
        step();
        idle_inputs();
        #1;
        check_eq("claim_wins", {31'd0, busy1}, 32'd1);
        check_eq("b9_data", rd_data1, 32'h0000_0099);
        wr_en_b = 1'b1; wr_addr_b = 5'd9; wr_data_b = 32'h0000_0999;
        #1;
        check_eq("clear_no_bypass", {31'd0, busy1}, 32'd1);
        step();
        idle_inputs();
        #1;
        check_eq("b9_clears", {31'd0, busy1}, 32'd0);

        // Port A does not touch pending bits
        claim_en = 1'b1; claim_addr = 5'd4;
        step();
        idle_inputs();
        wr_en_a = 1'b1; wr_addr_a = 5'd4; wr_data_a = 32'h0000_0444;
        rd_addr2 = 5'd4;
        step();
        idle_inputs();
        #1;
        check_eq("a4_keeps_busy", {31'd0, busy2}, 32'd1);

        // Fill every entry with 0x100+i and claim it
        for (int i = 0; i < 32; i++) begin
            wr_en_a = 1'b1; wr_addr_a = 5'(i); wr_data_a = 32'h100 + 32'(i);
            claim_en = 1'b1; claim_addr = 5'(i);
            step();
        end
        idle_inputs();
        rd_addr1 = 5'd20;
        rd_addr2 = 5'd3;
        #1;
        check_eq("fill_20", rd_data1, 32'h0000_0114);
        check_eq("fill_busy20", {31'd0, busy1}, 32'd1);

        // Sequential clear with writes, claims and clear_req held during it
        clear_req = 1'b1;
        step();
        check_eq("clr_busy_start", {31'd0, clear_busy}, 32'd1);
        wr_en_a = 1'b1; wr_addr_a = 5'd20; wr_data_a = 32'hDEAD_BEEF;
        wr_en_b = 1'b1; wr_addr_b = 5'd3;  wr_data_b = 32'hBEEF_DEAD;
        claim_en = 1'b1; claim_addr = 5'd2;
        cnt = 0;
        while (clear_busy && cnt < 100) begin
            if (cnt == 5) begin
                #1;
                check_eq("mid_clr_nobypass20", rd_data1, 32'h0000_0114);
                check_eq("mid_clr_cleared3", rd_data2, 32'h0);
                check_eq("mid_clr_busy20", {31'd0, busy1}, 32'd1);
            end
            cnt++;
            step();
        end
        idle_inputs();
        check_eq("clr_cycles", 32'(cnt), 32'd32);
        #1;
        for (int i = 0; i < 32; i++) begin
            rd_addr1 = 5'(i);
            #1;
            check_eq($sformatf("post_clr_data%0d", i), rd_data1, 32'h0);
            check_eq($sformatf("post_clr_busy%0d", i), {31'd0, busy1}, 32'd0);
        end
        step();
        check_eq("no_second_pass", {31'd0, clear_busy}, 32'd0);

        // Reset in the middle of a clear
        wr_en_a = 1'b1; wr_addr_a = 5'd15; wr_data_a = 32'h0000_0077;
        claim_en = 1'b1; claim_addr = 5'd15;
        step();
        idle_inputs();
        clear_req = 1'b1;
        step();
        clear_req = 1'b0;
        repeat (10) step();
        rd_addr1 = 5'd15;
        #1;
        check_eq("pre_rst_15", rd_data1, 32'h0000_0077);
        check_eq("pre_rst_clr_busy", {31'd0, clear_busy}, 32'd1);
        reset_n = 1'b0;
        #1;
        check_eq("async_rst_data", rd_data1, 32'h0);
        check_eq("async_rst_busy", {31'd0, busy1}, 32'd0);
        check_eq("async_rst_clr_busy", {31'd0, clear_busy}, 32'd0);
        @(negedge clock);
        reset_n = 1'b1;
        wr_en_a = 1'b1; wr_addr_a = 5'd21; wr_data_a = 32'h0000_2121;
        step();
        idle_inputs();
        rd_addr2 = 5'd21;
        #1;
        check_eq("post_rst_idle", {31'd0, clear_busy}, 32'd0);
        check_eq("post_rst_first_wr", rd_data2, 32'h0000_2121);
        check_eq("post_rst_15", rd_data1, 32'h0);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/bank_register_mp.md
BANK_REGISTER_MP -- requirements
Module: bank_register_mp

Interface
REQ-001 Parameter DATA_W, default 32: register width in bits.
REQ-002 Parameter ADDR_W, default 5: address width; DEPTH = 2**ADDR_W entries.
REQ-003 Parameter ZERO_REG, default 1: when 1, entry 0 always reads 0 and is never written or marked pending.
REQ-004 clock  input  1  single clock; all state updates on its rising edge.
REQ-005 reset_n  input  1  asynchronous, active-low reset.
REQ-006 rd_addr1, rd_addr2  input  ADDR_W each  read addresses.
REQ-007 rd_data1, rd_data2  output  DATA_W each  combinational read data, bypassed.
REQ-008 busy1, busy2  output  1 each  pending (scoreboard) bit of rd_addr1 / rd_addr2.
REQ-009 wr_en_a, wr_addr_a, wr_data_a  input  1/ADDR_W/DATA_W  write port A (ALU writeback).
REQ-010 wr_en_b, wr_addr_b, wr_data_b  input  1/ADDR_W/DATA_W  write port B (load writeback); also clears pending.
REQ-011 claim_en, claim_addr  input  1/ADDR_W  marks an entry pending (load issued).
REQ-012 clear_req  input  1  request a full sequential clear.
REQ-013 clear_busy  output  1  high while the clear sequence runs.

Function
REQ-014 Writes SHALL commit at the rising edge when the enable is high and the FSM is IDLE.
REQ-015 When wr_en_a and wr_en_b target the same address in one cycle, port A data SHALL be stored.
REQ-016 Read ports SHALL return the value being written this cycle if the address matches an enabled write (port A before port B), else the stored value: zero-cycle write-to-read bypass.
REQ-017 With ZERO_REG=1, reads of address 0 SHALL return 0 and writes/claims to address 0 SHALL be ignored, bypass included.
REQ-018 Pending bit SHALL set at the edge after claim_en with claim_addr; SHALL clear at the edge after wr_en_b writes that address.
REQ-019 Simultaneous claim and port-B clear of the same address SHALL leave the bit set (claim wins).
REQ-020 Port-A writes SHALL NOT affect pending bits.
REQ-021 busy1/busy2 SHALL reflect the registered pending bit, with no bypass of same-cycle claim or clear.
REQ-022 FSM states: IDLE, CLEAR. IDLE->CLEAR on clear_req; index counter loads 0.
REQ-023 In CLEAR, each cycle SHALL write 0 to entry[index] and clear pending[index], then increment index; after index DEPTH-1, return to IDLE. Total DEPTH cycles.
REQ-024 clear_busy SHALL be high exactly while in CLEAR.
REQ-025 In CLEAR, write ports, claims and clear_req SHALL be ignored and bypass disabled; reads return stored contents (partially cleared).
REQ-026 Index counter SHALL be ADDR_W bits; terminal detection at all-ones, no wrap into a second pass.

Reset
REQ-027 reset_n low SHALL immediately force all entries to 0, all pending bits to 0, FSM to IDLE, index to 0; clear_busy 0.
REQ-028 Reset asserted mid-CLEAR SHALL abort the sequence; after release, block is IDLE and fully zeroed.
REQ-029 After reset release, first write SHALL take effect at the first rising edge with reset_n high.

Verification
REQ-030 Write A addr 3 = 0x0000_1234, same cycle read addr 3 -> rd_data1 = 0x0000_1234 combinationally; next cycle stored value 0x0000_1234.
REQ-031 A and B both write addr 7 (0xAAAA_AAAA, 0x5555_5555) -> entry 7 = 0xAAAA_AAAA; bypass shows 0xAAAA_AAAA.
REQ-032 Write addr 0 = 0xFFFF_FFFF with ZERO_REG=1 -> rd_data 0 before and after; claim addr 0 -> busy stays 0.
REQ-033 claim 9; next cycle busy=1; B write 9 with claim 9 same cycle -> busy stays 1; B write 9 alone -> busy 0 next cycle.
REQ-034 Fill all entries, pulse clear_req -> clear_busy high 32 cycles (ADDR_W=5); writes during are dropped; afterwards all reads 0, all busy 0.
REQ-035 Assert reset_n low at CLEAR cycle 10, async -> all outputs zero, clear_busy 0 immediately, without a clock edge.
